// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline interlock: FSM states, bubble encoding, counter helpers.
// Purely declarative; no logic or timing of its own.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [15:0] NOP_INSTR_DEF = 16'hF000;
  localparam logic [3:0]  OP_NOP        = 4'hF;
  localparam int          CNT_W         = 3;

  function automatic logic [CNT_W-1:0] sat_inc3(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating event counter: counts cycles with inc_in high, sticks at all-ones, sync clear on rst.
// Registered output, one cycle after the counted event; never stalls its source.
module pipe_stall_ctrl_perf_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_in,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc_in && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_out = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline interlock: freezes PC/IF-ID on RAW hazards, bubbles ID/EX on stalls and flushes.
// Mealy outputs (same cycle as hazard_in/flush_in); STALL_PERF_EN adds saturating perf counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int          MAX_STALL    = 3,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [15:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_in,
  input  logic        flush_in,
  input  logic [15:0] instr_in,
  output logic [15:0] instr_out,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_clr,
  output logic        idex_bubble,
  output logic        stall_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [15:0] perf_stall_cyc,
  output logic [15:0] perf_flush_cyc,
  output logic [7:0]  perf_timeouts
`endif
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] FC_C  = CNT_W'(FLUSH_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_stall;
  logic [CNT_W-1:0] w_nxt_flush;
  logic             w_pc_en, w_ifid_en, w_ifid_clr, w_bubble, w_timeout;

  always_comb begin
    w_pc_en     = 1'b1;
    w_ifid_en   = 1'b1;
    w_ifid_clr  = 1'b0;
    w_bubble    = 1'b0;
    w_timeout   = 1'b0;
    w_nxt_state = r_state;
    w_nxt_stall = r_stall_cnt;
    w_nxt_flush = r_flush_cnt;
    // rst keeps the idle defaults; the register block restores RUN
    if (!rst) begin
      if (flush_in) begin
        w_ifid_clr  = 1'b1;
        w_bubble    = 1'b1;
        w_nxt_stall = '0;
        w_nxt_state = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        w_nxt_flush = (FLUSH_CYCLES == 1) ? '0 : CNT_W'(1);
      end else begin
        case (r_state)
          ST_RUN: begin
            if (hazard_in) begin
              w_pc_en     = 1'b0;
              w_ifid_en   = 1'b0;
              w_bubble    = 1'b1;
              w_nxt_state = ST_STALL;
              w_nxt_stall = CNT_W'(1);
            end
          end
          ST_STALL: begin
            if (hazard_in && (r_stall_cnt < MAX_C)) begin
              w_pc_en     = 1'b0;
              w_ifid_en   = 1'b0;
              w_bubble    = 1'b1;
              w_nxt_stall = sat_inc3(r_stall_cnt);
            end else begin
              w_timeout   = hazard_in;
              w_nxt_state = ST_RUN;
              w_nxt_stall = '0;
            end
          end
          ST_FLUSH: begin
            w_bubble = 1'b1;
            if (sat_inc3(r_flush_cnt) >= FC_C) begin
              w_nxt_state = ST_RUN;
              w_nxt_flush = '0;
            end else begin
              w_nxt_flush = sat_inc3(r_flush_cnt);
            end
          end
          default: begin
            w_nxt_state = ST_RUN;
            w_nxt_stall = '0;
            w_nxt_flush = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_stall_cnt <= w_nxt_stall;
      r_flush_cnt <= w_nxt_flush;
    end
  end

  assign pc_en         = w_pc_en;
  assign ifid_en       = w_ifid_en;
  assign ifid_clr      = w_ifid_clr;
  assign idex_bubble   = w_bubble;
  assign stall_timeout = w_timeout;
  assign instr_out     = w_bubble ? NOP_INSTR : instr_in;

`ifdef STALL_PERF_EN
  // Bubbles are attributed by cause: a flush entry cycle counts as flush even from RUN/STALL
  logic w_flush_bub, w_stall_bub;
  assign w_flush_bub = w_bubble & (flush_in | (r_state == ST_FLUSH));
  assign w_stall_bub = w_bubble & ~w_flush_bub;

  pipe_stall_ctrl_perf_cnt #(.WIDTH(16)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc_in(w_stall_bub), .cnt_out(perf_stall_cyc)
  );
  pipe_stall_ctrl_perf_cnt #(.WIDTH(16)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc_in(w_flush_bub), .cnt_out(perf_flush_cyc)
  );
  pipe_stall_ctrl_perf_cnt #(.WIDTH(8)) u_tmo_cnt (
    .clk(clk), .rst(rst), .inc_in(w_timeout), .cnt_out(perf_timeouts)
  );
`endif

endmodule
